// File: rtl/bft_defl_pkg.sv
// Shared types and constants for the bufferless deflection BFT pi-node switch.
package bft_defl_pkg;

  localparam int unsigned NPORT = 4;
  localparam int unsigned SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // Port indices; PORT_U0 as a desired port means "any up port" (U0, else U1).
  localparam sel_t PORT_L    = 3'd0;
  localparam sel_t PORT_R    = 3'd1;
  localparam sel_t PORT_U0   = 3'd2;
  localparam sel_t PORT_U1   = 3'd3;
  localparam sel_t PORT_NONE = 3'd4;

  // Packet layout for the default build (A_W=4, D_W=32, AGE_W=3).
  localparam int unsigned PKT_A_W   = 4;
  localparam int unsigned PKT_D_W   = 32;
  localparam int unsigned PKT_AGE_W = 3;

  typedef struct packed {
    logic                 v;
    logic                 defl;
    logic [PKT_AGE_W-1:0] age;
    logic [PKT_A_W-1:0]   addr;
    logic [PKT_D_W-1:0]   d;
  } pkt_t;

endpackage

// File: rtl/pi_defl_switch_if.sv
// Packet ports of the pi-node switch: four inputs, four outputs, conflict flag.
interface pi_defl_switch_if #(
  parameter int unsigned A_W   = 4,
  parameter int unsigned D_W   = 32,
  parameter int unsigned AGE_W = 3
);
  logic             l_i_v, r_i_v, u0_i_v, u1_i_v;
  logic             l_i_defl, r_i_defl, u0_i_defl, u1_i_defl;
  logic [AGE_W-1:0] l_i_age, r_i_age, u0_i_age, u1_i_age;
  logic [A_W-1:0]   l_i_addr, r_i_addr, u0_i_addr, u1_i_addr;
  logic [D_W-1:0]   l_i_d, r_i_d, u0_i_d, u1_i_d;

  logic             l_o_v, r_o_v, u0_o_v, u1_o_v;
  logic             l_o_defl, r_o_defl, u0_o_defl, u1_o_defl;
  logic [AGE_W-1:0] l_o_age, r_o_age, u0_o_age, u1_o_age;
  logic [A_W-1:0]   l_o_addr, r_o_addr, u0_o_addr, u1_o_addr;
  logic [D_W-1:0]   l_o_d, r_o_d, u0_o_d, u1_o_d;

  logic             conflict;

  modport master (
    output l_i_v, r_i_v, u0_i_v, u1_i_v,
    output l_i_defl, r_i_defl, u0_i_defl, u1_i_defl,
    output l_i_age, r_i_age, u0_i_age, u1_i_age,
    output l_i_addr, r_i_addr, u0_i_addr, u1_i_addr,
    output l_i_d, r_i_d, u0_i_d, u1_i_d,
    input  l_o_v, r_o_v, u0_o_v, u1_o_v,
    input  l_o_defl, r_o_defl, u0_o_defl, u1_o_defl,
    input  l_o_age, r_o_age, u0_o_age, u1_o_age,
    input  l_o_addr, r_o_addr, u0_o_addr, u1_o_addr,
    input  l_o_d, r_o_d, u0_o_d, u1_o_d,
    input  conflict
  );

  modport slave (
    input  l_i_v, r_i_v, u0_i_v, u1_i_v,
    input  l_i_defl, r_i_defl, u0_i_defl, u1_i_defl,
    input  l_i_age, r_i_age, u0_i_age, u1_i_age,
    input  l_i_addr, r_i_addr, u0_i_addr, u1_i_addr,
    input  l_i_d, r_i_d, u0_i_d, u1_i_d,
    output l_o_v, r_o_v, u0_o_v, u1_o_v,
    output l_o_defl, r_o_defl, u0_o_defl, u1_o_defl,
    output l_o_age, r_o_age, u0_o_age, u1_o_age,
    output l_o_addr, r_o_addr, u0_o_addr, u1_o_addr,
    output l_o_d, r_o_d, u0_o_d, u1_o_d,
    output conflict
  );
endinterface

// File: rtl/pi_defl_alloc.sv
// Combinational output allocator for the pi-node switch.
// Optional feature macro: AGE_PRIO_EN (older packets first, round-robin breaks ties).
module pi_defl_alloc
  import bft_defl_pkg::*;
#(
  parameter int unsigned AGE_W = 3
) (
  input  logic             v      [NPORT],
  input  sel_t             want   [NPORT],
  input  logic [AGE_W-1:0] age    [NPORT],
  input  logic [1:0]       rr_ptr,
  output sel_t             sel    [NPORT],
  output logic             defl   [NPORT]
);

  logic [1:0] rank [NPORT];
  logic [1:0] pos  [NPORT];
  logic [2:0] cnt;
  logic       better;
  logic [3:0] busy;
  logic [3:0] placed;
  logic       got;

`ifndef AGE_PRIO_EN
  logic unused_age;
  assign unused_age = ^{age[0], age[1], age[2], age[3]};
`endif

  // Priority position of each input: number of inputs that outrank it.
  always_comb begin
    cnt    = '0;
    better = 1'b0;
    for (int i = 0; i < 4; i++) rank[i] = 2'(i) - rr_ptr;
    for (int i = 0; i < 4; i++) begin
      cnt = '0;
      for (int j = 0; j < 4; j++) begin
        if (j != i) begin
`ifdef AGE_PRIO_EN
          better = (age[j] > age[i]) || ((age[j] == age[i]) && (rank[j] < rank[i]));
`else
          better = rank[j] < rank[i];
`endif
          if (better) cnt = cnt + 3'd1;
        end
      end
      pos[i] = cnt[1:0];
    end
  end

  // Winners claim desired outputs in priority order, then losers take the lowest free output.
  always_comb begin
    busy   = '0;
    placed = '0;
    got    = 1'b0;
    for (int o = 0; o < 4; o++) begin
      sel[o]  = PORT_NONE;
      defl[o] = 1'b0;
    end
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && (pos[i] == 2'(p))) begin
          if (want[i] == PORT_U0) begin
            if (!busy[2]) begin
              busy[2] = 1'b1; sel[2] = SEL_W'(i); placed[i] = 1'b1;
            end else if (!busy[3]) begin
              busy[3] = 1'b1; sel[3] = SEL_W'(i); placed[i] = 1'b1;
            end
          end else if (!busy[want[i][1:0]]) begin
            busy[want[i][1:0]] = 1'b1;
            sel[want[i][1:0]]  = SEL_W'(i);
            placed[i]          = 1'b1;
          end
        end
      end
    end
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) begin
        if (v[i] && !placed[i] && (pos[i] == 2'(p))) begin
          got = 1'b0;
          for (int o = 0; o < 4; o++) begin
            if (!got && !busy[o]) begin
              busy[o] = 1'b1;
              sel[o]  = SEL_W'(i);
              got     = 1'b1;
            end
          end
          defl[i] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/pi_defl_switch.sv
// Registered 4-port pi-node deflection switch with age priority and round-robin tie-break.
// Optional feature macro: AGE_PRIO_EN (handled in pi_defl_alloc).
module pi_defl_switch
  import bft_defl_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned A_W   = $clog2(N) + 1,
  parameter int unsigned D_W   = 32,
  parameter int unsigned AGE_W = 3,
  parameter int unsigned POSL  = 0,
  parameter int unsigned POSX  = 0
) (
  input logic             clk,
  input logic             rst,
  input logic             ce,
  pi_defl_switch_if.slave bus
);

  localparam int unsigned     PW      = A_W - POSL - 1;
  localparam logic [AGE_W-1:0] AGE_MAX = '1;

  logic             in_v    [NPORT];
  logic [AGE_W-1:0] in_age  [NPORT];
  logic [A_W-1:0]   in_addr [NPORT];
  logic [D_W-1:0]   in_d    [NPORT];
  sel_t             want    [NPORT];
  sel_t             out_sel [NPORT];
  logic             lose    [NPORT];

  logic             nxt_v    [NPORT];
  logic             nxt_defl [NPORT];
  logic [AGE_W-1:0] nxt_age  [NPORT];
  logic [A_W-1:0]   nxt_addr [NPORT];
  logic [D_W-1:0]   nxt_d    [NPORT];
  logic             conflict_c;

  logic             o_v    [NPORT];
  logic             o_defl [NPORT];
  logic [AGE_W-1:0] o_age  [NPORT];
  logic [A_W-1:0]   o_addr [NPORT];
  logic [D_W-1:0]   o_d    [NPORT];
  logic             conflict_q;
  logic [1:0]       rr_ptr;

  logic [1:0]       idx;
  logic             lcl;

  // Upstream deflection history does not influence this node's decisions.
  logic unused_defl;
  assign unused_defl = ^{bus.l_i_defl, bus.r_i_defl, bus.u0_i_defl, bus.u1_i_defl};

  // Gather the interface inputs into per-port arrays.
  always_comb begin
    in_v    = '{bus.l_i_v,    bus.r_i_v,    bus.u0_i_v,    bus.u1_i_v};
    in_age  = '{bus.l_i_age,  bus.r_i_age,  bus.u0_i_age,  bus.u1_i_age};
    in_addr = '{bus.l_i_addr, bus.r_i_addr, bus.u0_i_addr, bus.u1_i_addr};
    in_d    = '{bus.l_i_d,    bus.r_i_d,    bus.u0_i_d,    bus.u1_i_d};
  end

  // Desired output: non-local packets from below go up, everything else picks L/R by addr[POSL].
  always_comb begin
    lcl = 1'b0;
    for (int i = 0; i < 4; i++) begin
      lcl = in_addr[i][A_W-1 -: PW] == PW'(POSX);
      if ((i < 2) && !lcl) want[i] = PORT_U0;
      else                 want[i] = in_addr[i][POSL] ? PORT_R : PORT_L;
    end
  end

  pi_defl_alloc #(.AGE_W(AGE_W)) u_alloc (
    .v      (in_v),
    .want   (want),
    .age    (in_age),
    .rr_ptr (rr_ptr),
    .sel    (out_sel),
    .defl   (lose)
  );

  // Output muxes: deflected packets are marked and aged (saturating).
  always_comb begin
    idx        = '0;
    conflict_c = 1'b0;
    for (int o = 0; o < 4; o++) begin
      nxt_v[o]    = 1'b0;
      nxt_defl[o] = 1'b0;
      nxt_age[o]  = '0;
      nxt_addr[o] = '0;
      nxt_d[o]    = '0;
      if (out_sel[o] != PORT_NONE) begin
        idx         = out_sel[o][1:0];
        nxt_v[o]    = 1'b1;
        nxt_defl[o] = lose[idx];
        nxt_age[o]  = (lose[idx] && (in_age[idx] != AGE_MAX)) ? in_age[idx] + 1'b1 : in_age[idx];
        nxt_addr[o] = in_addr[idx];
        nxt_d[o]    = in_d[idx];
      end
      conflict_c = conflict_c | lose[o];
    end
  end

  // Output registers and round-robin pointer; reset overrides clock enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 4; o++) begin
        o_v[o]    <= 1'b0;
        o_defl[o] <= 1'b0;
        o_age[o]  <= '0;
        o_addr[o] <= '0;
        o_d[o]    <= '0;
      end
      conflict_q <= 1'b0;
      rr_ptr     <= 2'd0;
    end else if (ce) begin
      for (int o = 0; o < 4; o++) begin
        o_v[o]    <= nxt_v[o];
        o_defl[o] <= nxt_defl[o];
        o_age[o]  <= nxt_age[o];
        o_addr[o] <= nxt_addr[o];
        o_d[o]    <= nxt_d[o];
      end
      conflict_q <= conflict_c;
      if (conflict_c) rr_ptr <= rr_ptr + 2'd1;
    end
  end

  assign bus.l_o_v     = o_v[0];
  assign bus.r_o_v     = o_v[1];
  assign bus.u0_o_v    = o_v[2];
  assign bus.u1_o_v    = o_v[3];
  assign bus.l_o_defl  = o_defl[0];
  assign bus.r_o_defl  = o_defl[1];
  assign bus.u0_o_defl = o_defl[2];
  assign bus.u1_o_defl = o_defl[3];
  assign bus.l_o_age   = o_age[0];
  assign bus.r_o_age   = o_age[1];
  assign bus.u0_o_age  = o_age[2];
  assign bus.u1_o_age  = o_age[3];
  assign bus.l_o_addr  = o_addr[0];
  assign bus.r_o_addr  = o_addr[1];
  assign bus.u0_o_addr = o_addr[2];
  assign bus.u1_o_addr = o_addr[3];
  assign bus.l_o_d     = o_d[0];
  assign bus.r_o_d     = o_d[1];
  assign bus.u0_o_d    = o_d[2];
  assign bus.u1_o_d    = o_d[3];
  assign bus.conflict  = conflict_q;

endmodule

// File: tb/tb_pi_defl_switch.sv
// Bench for pi_defl_switch (N=8, POSL=0, POSX=0): reference model plus directed/random vectors.
module tb_pi_defl_switch;
  import bft_defl_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ce  = 1'b1;
  int   tests = 0;
  int   fails = 0;

  pi_defl_switch_if #(.A_W(4), .D_W(32), .AGE_W(3)) bus ();

  pi_defl_switch #(.N(8), .A_W(4), .D_W(32), .AGE_W(3), .POSL(0), .POSX(0)) dut (
    .clk (clk),
    .rst (rst),
    .ce  (ce),
    .bus (bus)
  );

  always #5 clk = ~clk;

  pkt_t drv [4];
  pkt_t expk [4];
  logic exp_conf = 1'b0;
  int   exp_cnt  = 0;
  int   mrr      = 0;
  bit   chk_en   = 1'b0;

  always_comb begin
    bus.l_i_v  = drv[0].v;    bus.r_i_v  = drv[1].v;    bus.u0_i_v  = drv[2].v;    bus.u1_i_v  = drv[3].v;
    bus.l_i_defl = drv[0].defl; bus.r_i_defl = drv[1].defl; bus.u0_i_defl = drv[2].defl; bus.u1_i_defl = drv[3].defl;
    bus.l_i_age  = drv[0].age;  bus.r_i_age  = drv[1].age;  bus.u0_i_age  = drv[2].age;  bus.u1_i_age  = drv[3].age;
    bus.l_i_addr = drv[0].addr; bus.r_i_addr = drv[1].addr; bus.u0_i_addr = drv[2].addr; bus.u1_i_addr = drv[3].addr;
    bus.l_i_d    = drv[0].d;    bus.r_i_d    = drv[1].d;    bus.u0_i_d    = drv[2].d;    bus.u1_i_d    = drv[3].d;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: order valid packets (rr rotation, then stable sort by age), grant, then deflect.
  int order[$];
  int losers[$];
  int acc[$];
  bit taken [4];
  int tmp, ii, bb;
  bit got;
  always @(posedge clk) begin
    if (rst) begin
      for (int o = 0; o < 4; o++) expk[o] = '0;
      exp_conf = 1'b0;
      exp_cnt  = 0;
      mrr      = 0;
      chk_en   = 1'b1;
    end else if (ce) begin
      order = {};
      losers = {};
      for (int k = 0; k < 4; k++) if (drv[(mrr + k) % 4].v) order.push_back((mrr + k) % 4);
`ifdef AGE_PRIO_EN
      for (int a = 1; a < order.size(); a++) begin
        bb = a;
        while (bb > 0 && drv[order[bb]].age > drv[order[bb-1]].age) begin
          tmp = order[bb]; order[bb] = order[bb-1]; order[bb-1] = tmp;
          bb--;
        end
      end
`endif
      for (int o = 0; o < 4; o++) begin expk[o] = '0; taken[o] = 1'b0; end
      foreach (order[n]) begin
        ii = order[n];
        if (ii < 2 && drv[ii].addr[3:1] != 3'd0) acc = {2, 3};
        else acc = {int'(drv[ii].addr[0])};
        got = 1'b0;
        foreach (acc[m]) if (!got && !taken[acc[m]]) begin
          expk[acc[m]] = drv[ii]; expk[acc[m]].defl = 1'b0;
          taken[acc[m]] = 1'b1; got = 1'b1;
        end
        if (!got) losers.push_back(ii);
      end
      foreach (losers[n]) begin
        ii = losers[n];
        got = 1'b0;
        for (int o = 0; o < 4; o++) if (!got && !taken[o]) begin
          expk[o] = drv[ii];
          expk[o].defl = 1'b1;
          expk[o].age = (drv[ii].age == 3'd7) ? 3'd7 : drv[ii].age + 3'd1;
          taken[o] = 1'b1; got = 1'b1;
        end
      end
      exp_conf = losers.size() != 0;
      exp_cnt  = order.size();
      if (exp_conf) mrr = (mrr + 1) % 4;
    end
  end

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("l_o",  64'({bus.l_o_v,  bus.l_o_defl,  bus.l_o_age,  bus.l_o_addr,  bus.l_o_d}),  64'(expk[0]));
      chk("r_o",  64'({bus.r_o_v,  bus.r_o_defl,  bus.r_o_age,  bus.r_o_addr,  bus.r_o_d}),  64'(expk[1]));
      chk("u0_o", 64'({bus.u0_o_v, bus.u0_o_defl, bus.u0_o_age, bus.u0_o_addr, bus.u0_o_d}), 64'(expk[2]));
      chk("u1_o", 64'({bus.u1_o_v, bus.u1_o_defl, bus.u1_o_age, bus.u1_o_addr, bus.u1_o_d}), 64'(expk[3]));
      chk("conflict", 64'(bus.conflict), 64'(exp_conf));
      chk("conservation", 64'(int'(bus.l_o_v) + int'(bus.r_o_v) + int'(bus.u0_o_v) + int'(bus.u1_o_v)),
          64'(exp_cnt));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int i = 0; i < 4; i++) drv[i] = '0;
  endtask

  function automatic pkt_t mk(input logic [2:0] age, input logic [3:0] addr, input logic [31:0] d);
    pkt_t p;
    p = '0; p.v = 1'b1; p.age = age; p.addr = addr; p.d = d;
    return p;
  endfunction

  initial begin
    clr();
    rst = 1'b1; ce = 1'b1;
    step(); step();
    chk("rst_v", 64'({bus.l_o_v, bus.r_o_v, bus.u0_o_v, bus.u1_o_v, bus.conflict}), 64'd0);
    rst = 1'b0;

    // Idle-else: local client 1 goes out on R.
    drv[0] = mk(3'd0, 4'd1, 32'hA5);
    step(); clr();
    chk("idle_r_v", 64'(bus.r_o_v), 64'd1);
    chk("idle_r_d", 64'(bus.r_o_d), 64'hA5);
    chk("idle_r_defl", 64'(bus.r_o_defl), 64'd0);
    chk("idle_others", 64'({bus.l_o_v, bus.u0_o_v, bus.u1_o_v, bus.conflict}), 64'd0);

    // Dual up.
    drv[0] = mk(3'd0, 4'd5, 32'h11);
    drv[1] = mk(3'd0, 4'd6, 32'h22);
    step(); clr();
    chk("up_u0_d", 64'(bus.u0_o_d), 64'h11);
    chk("up_u1_d", 64'(bus.u1_o_d), 64'h22);
    chk("up_conf", 64'({bus.u0_o_defl, bus.u1_o_defl, bus.conflict}), 64'd0);

    // Down contention, rr_ptr=0.
    drv[2] = mk(3'd0, 4'd0, 32'h33);
    drv[3] = mk(3'd0, 4'd0, 32'h44);
    step(); clr();
    chk("dn_l_d", 64'(bus.l_o_d), 64'h33);
    chk("dn_r_d", 64'(bus.r_o_d), 64'h44);
    chk("dn_r_defl_age", 64'({bus.r_o_defl, bus.r_o_age}), 64'({1'b1, 3'd1}));
    chk("dn_conf", 64'(bus.conflict), 64'd1);

    // Age priority, rr_ptr=1 (U0 still outranks U1 on round-robin).
    drv[2] = mk(3'd0, 4'd0, 32'h33);
    drv[3] = mk(3'd3, 4'd0, 32'h44);
    step(); clr();
`ifdef AGE_PRIO_EN
    chk("age_l_d", 64'(bus.l_o_d), 64'h44);
    chk("age_r", 64'({bus.r_o_d[7:0], bus.r_o_defl, bus.r_o_age}), 64'({8'h33, 1'b1, 3'd1}));
`else
    chk("age_l_d", 64'(bus.l_o_d), 64'h33);
    chk("age_r", 64'({bus.r_o_d[7:0], bus.r_o_defl, bus.r_o_age}), 64'({8'h44, 1'b1, 3'd4}));
`endif

    // Saturation: both at max age, loser keeps age 7.
    drv[2] = mk(3'd7, 4'd0, 32'h55);
    drv[3] = mk(3'd7, 4'd0, 32'h66);
    step(); clr();
    chk("sat_r", 64'({bus.r_o_v, bus.r_o_defl, bus.r_o_age}), 64'({1'b1, 1'b1, 3'd7}));

    // All four want L, rr_ptr=3: U1 wins, L/R/U0 deflect to R/U0/U1.
    for (int i = 0; i < 4; i++) drv[i] = mk(3'd0, 4'd0, 32'h70 + 32'(i));
    step();
    chk("all_l_d", 64'(bus.l_o_d), 64'h73);
    chk("all_defl", 64'({bus.l_o_defl, bus.r_o_defl, bus.u0_o_defl, bus.u1_o_defl}), 64'b0111);
    chk("all_r_d", 64'(bus.r_o_d), 64'h70);

    // ce=0 holds state while inputs change.
    ce = 1'b0;
    drv[0] = mk(3'd2, 4'd1, 32'h99);
    step(); step();
    chk("hold_l_d", 64'(bus.l_o_d), 64'h73);
    chk("hold_conf", 64'(bus.conflict), 64'd1);

    // Reset with ce=0 still clears.
    rst = 1'b1;
    step();
    chk("rst_ce0", 64'({bus.l_o_v, bus.r_o_v, bus.u0_o_v, bus.u1_o_v, bus.conflict}), 64'd0);
    rst = 1'b0; ce = 1'b1;
    clr();

    // Random heavy traffic, with occasional clock-enable drops and resets.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        drv[i]      = '0;
        drv[i].v    = ($urandom_range(0, 7) != 0);
        drv[i].defl = 1'($urandom_range(0, 1));
        drv[i].age  = 3'($urandom_range(0, 7));
        drv[i].addr = 4'($urandom_range(0, 7));
        drv[i].d    = $urandom;
      end
      ce  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 199) == 0);
      step();
    end
    rst = 1'b0; ce = 1'b1;
    clr();
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
